// File: rtl/cam_stream_gen_pkg.sv
// Shared camera-path definitions: FSM state encoding, RGB332/RGB565 field positions
// and the RGB332 -> RGB565 expansion used by both the source and the capture side.
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VFRONT = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VBACK  = 3'd4
  } cam_state_e;

  localparam int R332_LSB = 5;
  localparam int G332_LSB = 2;
  localparam int B332_LSB = 0;
  localparam int R565_LSB = 11;
  localparam int G565_LSB = 5;
  localparam int B565_LSB = 0;

  // Widening by bit replication keeps full-scale white at full scale.
  function automatic logic [15:0] rgb332_to_rgb565(input logic [7:0] p);
    logic [2:0]  r;
    logic [2:0]  g;
    logic [1:0]  b;
    logic [15:0] o;
    r = p[R332_LSB +: 3];
    g = p[G332_LSB +: 3];
    b = p[B332_LSB +: 2];
    o = '0;
    o[R565_LSB +: 5] = {r, r[2:1]};
    o[G565_LSB +: 6] = {g, g};
    o[B565_LSB +: 5] = {b, b, b[1]};
    return o;
  endfunction

endpackage

// File: rtl/cam_stream_gen_if.sv
// Framebuffer read port plus the framed pixel-byte stream of the camera source.
// master = the stream generator, slave = RAM / capture side.
interface cam_stream_gen_if #(
  parameter int AW = 17,
  parameter int DW = 8
);
  logic [AW-1:0] mem_px_addr;
  logic          mem_px_rd;
  logic [DW-1:0] mem_px_data;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic          frame_done;

  modport master (
    output mem_px_addr, mem_px_rd, vsync, href, px_data, frame_done,
    input  mem_px_data
  );

  modport slave (
    input  mem_px_addr, mem_px_rd, vsync, href, px_data, frame_done,
    output mem_px_data
  );
endinterface

// File: rtl/cam_timing_gen.sv
// Frame/line timing: state machine, column/line counters, vsync/href/frame_done and the
// pixel-fetch strobe for the following cycle (fetch_nxt_o, to be registered by the caller).
module cam_timing_gen
  import cam_pkg::*;
#(
  parameter int H_PIX    = 160,
  parameter int H_BLANK  = 16,
  parameter int V_LINES  = 120,
  parameter int VSYNC_LN = 3,
  parameter int V_FRONT  = 2,
  parameter int V_BACK   = 2
) (
  input  logic pclk,
  input  logic rst,
  input  logic en_i,
  output logic vsync_o,
  output logic href_o,
  output logic frame_done_o,
  output logic fetch_nxt_o
);

  localparam int LINE_LEN = 2 * H_PIX + H_BLANK;
  localparam int CW       = $clog2(LINE_LEN);
  localparam int LW       = $clog2(VSYNC_LN + V_FRONT + V_LINES + V_BACK + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
  localparam logic [CW-1:0] COL_PRE  = CW'(LINE_LEN - 2);
  localparam logic [CW-1:0] COL_ACT  = CW'(2 * H_PIX);
  localparam logic [CW-1:0] COL_FEND = CW'(2 * H_PIX - 2);
  localparam logic [LW-1:0] VS_LAST  = LW'(VSYNC_LN - 1);
  localparam logic [LW-1:0] VF_LAST  = LW'(V_FRONT - 1);
  localparam logic [LW-1:0] VA_LAST  = LW'(V_LINES - 1);
  localparam logic [LW-1:0] VB_LAST  = LW'(V_BACK - 1);

  cam_state_e    state_q, state_d, phase_next;
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] line_q, line_d, phase_last;
  logic          vsync_q, href_q, done_q;
  logic          vsync_d, href_d, done_d, fetch_d, next_line_act;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    line_d     = line_q;
    phase_last = '0;
    phase_next = ST_IDLE;
    case (state_q)
      ST_VSYNC:  begin phase_last = VS_LAST; phase_next = ST_VFRONT; end
      ST_VFRONT: begin phase_last = VF_LAST; phase_next = ST_ACTIVE; end
      ST_ACTIVE: begin phase_last = VA_LAST; phase_next = ST_VBACK;  end
      ST_VBACK:  begin phase_last = VB_LAST; phase_next = en_i ? ST_VSYNC : ST_IDLE; end
      default:   begin phase_last = '0;      phase_next = ST_IDLE;   end
    endcase
    if (state_q == ST_IDLE) begin
      if (en_i) state_d = ST_VSYNC;
    end else if (col_q == COL_LAST) begin
      col_d = '0;
      if (line_q == phase_last) begin
        line_d  = '0;
        state_d = phase_next;
      end else begin
        line_d = line_q + 1'b1;
      end
    end else begin
      col_d = col_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state so the registers line up with state_q.
  always_comb begin
    vsync_d       = (state_d == ST_VSYNC);
    href_d        = (state_d == ST_ACTIVE) && (col_d < COL_ACT);
    done_d        = (state_d == ST_VBACK) && (line_d == VB_LAST) && (col_d == COL_LAST);
    next_line_act = ((state_d == ST_VFRONT) && (line_d == VF_LAST)) ||
                    ((state_d == ST_ACTIVE) && (line_d != VA_LAST));
    // Pixel 0 is prefetched from the tail of the preceding blank; pixels 1.. from the line itself.
    fetch_d       = ((state_d == ST_ACTIVE) && !col_d[0] && (col_d < COL_FEND)) ||
                    (next_line_act && (col_d == COL_PRE));
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      line_q  <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      done_q  <= done_d;
    end
  end

  assign vsync_o      = vsync_q;
  assign href_o       = href_q;
  assign frame_done_o = done_q;
  assign fetch_nxt_o  = fetch_d;

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670-style pixel source: framebuffer fetch, RGB332->RGB565 expansion, two bytes per pixel.
// Optional colour-bar generator built only when CAM_TEST_PATTERN_EN is defined.
module cam_stream_gen
  import cam_pkg::*;
#(
  parameter int AW       = 17,
  parameter int DW       = 8,
  parameter int H_PIX    = 160,
  parameter int H_BLANK  = 16,
  parameter int V_LINES  = 120,
  parameter int VSYNC_LN = 3,
  parameter int V_FRONT  = 2,
  parameter int V_BACK   = 2
) (
  input  logic pclk,
  input  logic rst,
  input  logic en,
  input  logic pattern_sel,
  cam_stream_gen_if.master bus
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(H_PIX * V_LINES - 1);

  logic          vsync_w, href_w, done_w, fetch_nxt_w;
  logic          pat_on;
  logic [7:0]    src_px;
  logic [15:0]   px565;
  logic          rd_q, fetch_q, ld_q, lo_pend_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    px_q, lo_q;

  cam_timing_gen #(
    .H_PIX   (H_PIX),
    .H_BLANK (H_BLANK),
    .V_LINES (V_LINES),
    .VSYNC_LN(VSYNC_LN),
    .V_FRONT (V_FRONT),
    .V_BACK  (V_BACK)
  ) u_timing (
    .pclk        (pclk),
    .rst         (rst),
    .en_i        (en),
    .vsync_o     (vsync_w),
    .href_o      (href_w),
    .frame_done_o(done_w),
    .fetch_nxt_o (fetch_nxt_w)
  );

`ifdef CAM_TEST_PATTERN_EN
  localparam int PCW = $clog2(H_PIX + 1);
  localparam logic [PCW-1:0] PCOL_LAST = PCW'(H_PIX - 1);

  logic [PCW-1:0] pcol_q;
  logic [7:0]     pat_px_q;
  logic [2:0]     bar;

  assign pat_on = pattern_sel;
  assign bar    = 3'((32'(pcol_q) * 32'd8) / 32'(H_PIX));
  assign src_px = pattern_sel ? pat_px_q : 8'(bus.mem_px_data);

  // Bar pixel is built in the fetch cycle so it lands where RAM data would.
  always_ff @(posedge pclk) begin
    if (rst) begin
      pcol_q   <= '0;
      pat_px_q <= '0;
    end else begin
      if (vsync_w)
        pcol_q <= '0;
      else if (fetch_q)
        pcol_q <= (pcol_q == PCOL_LAST) ? '0 : pcol_q + 1'b1;
      pat_px_q <= {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
    end
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign pat_on             = 1'b0;
  assign src_px             = 8'(bus.mem_px_data);
`endif

  assign px565 = rgb332_to_rgb565(src_px);

  // fetch_q: issue cycle, ld_q: RAM data valid, then byte0 and byte1 on consecutive cycles.
  always_ff @(posedge pclk) begin
    if (rst) begin
      rd_q      <= 1'b0;
      fetch_q   <= 1'b0;
      ld_q      <= 1'b0;
      lo_pend_q <= 1'b0;
      addr_q    <= '0;
      px_q      <= '0;
      lo_q      <= '0;
    end else begin
      rd_q    <= fetch_nxt_w & ~pat_on;
      fetch_q <= fetch_nxt_w;
      ld_q    <= fetch_q;
      if (vsync_w)
        addr_q <= '0;
      else if (fetch_q && (addr_q != ADDR_LAST))
        addr_q <= addr_q + 1'b1;
      if (ld_q) begin
        px_q      <= px565[15:8];
        lo_q      <= px565[7:0];
        lo_pend_q <= 1'b1;
      end else if (lo_pend_q) begin
        px_q      <= lo_q;
        lo_pend_q <= 1'b0;
      end else begin
        px_q <= '0;
      end
    end
  end

  assign bus.mem_px_addr = addr_q;
  assign bus.mem_px_rd   = rd_q;
  assign bus.vsync       = vsync_w;
  assign bus.href        = href_w;
  assign bus.px_data     = px_q;
  assign bus.frame_done  = done_w;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Bench for cam_stream_gen with a small frame geometry; expected stream derived per frame
// from the framing/addressing/expansion rules using plain arithmetic.
module tb_cam_stream_gen;

  localparam int AW       = 17;
  localparam int DW       = 8;
  localparam int H_PIX    = 4;
  localparam int H_BLANK  = 4;
  localparam int V_LINES  = 2;
  localparam int VSYNC_LN = 1;
  localparam int V_FRONT  = 1;
  localparam int V_BACK   = 1;
  localparam int LINE     = 2 * H_PIX + H_BLANK;
  localparam int FRAME    = (VSYNC_LN + V_FRONT + V_LINES + V_BACK) * LINE;
  localparam int NPIX     = H_PIX * V_LINES;

  typedef struct {
    logic [7:0] px;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;

  logic pclk = 1'b0;
  logic rst, en, pattern_sel;
  logic [7:0] ram [NPIX];
  logic [7:0] cap_px [FRAME];
  vec_t vec [NPIX];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  cam_stream_gen_if #(.AW(AW), .DW(DW)) bus ();

  cam_stream_gen #(
    .AW(AW), .DW(DW), .H_PIX(H_PIX), .H_BLANK(H_BLANK), .V_LINES(V_LINES),
    .VSYNC_LN(VSYNC_LN), .V_FRONT(V_FRONT), .V_BACK(V_BACK)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .en         (en),
    .pattern_sel(pattern_sel),
    .bus        (bus)
  );

  // Synchronous-read framebuffer
  always @(posedge pclk) begin
    if (bus.mem_px_rd)
      bus.mem_px_data <= (bus.mem_px_addr < 17'(NPIX)) ? ram[bus.mem_px_addr[2:0]] : 8'h00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int exp565(input int p);
    int r, g, b;
    r = p / 32;
    g = (p / 4) % 8;
    b = p % 4;
    return (r * 4 + r / 2) * 2048 + (g * 9) * 32 + (b * 10 + b / 2);
  endfunction

  function automatic int byte0_time(input int n);
    return (VSYNC_LN + V_FRONT + n / H_PIX) * LINE + 2 * (n % H_PIX);
  endfunction

  function automatic int src_px(input int n, input bit pat);
    int bar;
    bar = (n % H_PIX) * 8 / H_PIX;
`ifdef CAM_TEST_PATTERN_EN
    if (pat) return (bar / 4) * 224 + ((bar / 2) % 2) * 28 + (bar % 2) * 3;
`endif
    if (bar < 0) return 0;
    return pat ? int'(ram[n]) : int'(ram[n]);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vsync"}, 32'(bus.vsync), 0);
    chk({tag, "_href"},  32'(bus.href), 0);
    chk({tag, "_px"},    32'(bus.px_data), 0);
    chk({tag, "_rd"},    32'(bus.mem_px_rd), 0);
    chk({tag, "_done"},  32'(bus.frame_done), 0);
  endtask

  // Runs one frame from its first vsync cycle. drop_at: cycle at which en falls;
  // rst_at: cycle after which a one-cycle reset is applied and the frame abandoned.
  task automatic run_frame(input int drop_at, input int rst_at, input bit pat);
    int vs_e [FRAME];
    int hr_e [FRAME];
    int px_e [FRAME];
    int rd_e [FRAME];
    int ad_e [FRAME];
    int n_rd, n_hr, n_fd, line, col, a, w, t;
    bit aborted, pat_act;
    pat_act = 1'b0;
`ifdef CAM_TEST_PATTERN_EN
    pat_act = pat;
`endif
    for (int k = 0; k < FRAME; k++) begin
      line = k / LINE;
      col  = k % LINE;
      a    = line - VSYNC_LN - V_FRONT;
      vs_e[k] = (line < VSYNC_LN) ? 1 : 0;
      hr_e[k] = (a >= 0 && a < V_LINES && col < 2 * H_PIX) ? 1 : 0;
      px_e[k] = 0;
      rd_e[k] = 0;
      ad_e[k] = 0;
      if (hr_e[k] == 1) begin
        w = exp565(src_px(a * H_PIX + col / 2, pat));
        px_e[k] = (col % 2 == 0) ? w / 256 : w % 256;
      end
    end
    for (int n = 0; n < NPIX; n++) begin
      t = byte0_time(n) - 2;
      if (!pat_act) begin
        rd_e[t] = 1;
        ad_e[t] = n;
      end
    end
    n_rd = 0; n_hr = 0; n_fd = 0; aborted = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      @(posedge pclk); #1;
      chk("vsync", 32'(bus.vsync), vs_e[k]);
      chk("href",  32'(bus.href), hr_e[k]);
      chk("px",    32'(bus.px_data), px_e[k]);
      chk("rd",    32'(bus.mem_px_rd), rd_e[k]);
      chk("done",  32'(bus.frame_done), (k == FRAME - 1) ? 1 : 0);
      if (rd_e[k] == 1) chk("addr", 32'(bus.mem_px_addr), ad_e[k]);
      cap_px[k] = bus.px_data;
      n_rd += int'(bus.mem_px_rd);
      n_hr += int'(bus.href);
      n_fd += int'(bus.frame_done);
      if (k == drop_at) en = 1'b0;
      if (k == rst_at) begin
        rst = 1'b1;
        @(posedge pclk); #1;
        chk_all_zero("rst_mid");
        chk("rst_mid_addr", 32'(bus.mem_px_addr), 0);
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      chk("rd_count",   n_rd, pat_act ? 0 : NPIX);
      chk("href_count", n_hr, 2 * NPIX);
      chk("done_count", n_fd, 1);
    end
  endtask

  initial begin
    vec[0] = '{8'hE0, 8'hF8, 8'h00};
    vec[1] = '{8'h1C, 8'h07, 8'hE0};
    vec[2] = '{8'h03, 8'h00, 8'h1F};
    vec[3] = '{8'hFF, 8'hFF, 8'hFF};
    vec[4] = '{8'h00, 8'h00, 8'h00};
    vec[5] = '{8'h49, 8'h4A, 8'h4A};
    vec[6] = '{8'h92, 8'h94, 8'h95};
    vec[7] = '{8'h6D, 8'h6B, 8'h6A};

    for (int i = 0; i < NPIX; i++) ram[i] = 8'(8'h10 * i + i);
    rst = 1'b1; en = 1'b0; pattern_sel = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      chk_all_zero("reset");
      chk("reset_addr", 32'(bus.mem_px_addr), 0);
    end
    rst = 1'b0; en = 1'b1;

    run_frame(-1, -1, 1'b0);

    // Table-driven expansion frame, back-to-back with the first
    for (int i = 0; i < NPIX; i++) ram[i] = vec[i].px;
    run_frame(-1, -1, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      chk("tbl_byte0", 32'(cap_px[byte0_time(i)]), 32'(vec[i].b0));
      chk("tbl_byte1", 32'(cap_px[byte0_time(i) + 1]), 32'(vec[i].b1));
    end

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NPIX; i++) ram[i] = 8'($urandom);
      run_frame(-1, -1, 1'b0);
    end

    // en dropped during line 0: frame completes, then stays idle
    for (int i = 0; i < NPIX; i++) ram[i] = 8'($urandom);
    run_frame(5, -1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge pclk); #1;
      chk_all_zero("idle");
    end
    en = 1'b1;
    run_frame(-1, -1, 1'b0);

    // Reset in the middle of the first active line, then a full frame
    run_frame(-1, VSYNC_LN * LINE + V_FRONT * LINE + 6, 1'b0);
    for (int i = 0; i < NPIX; i++) ram[i] = 8'($urandom);
    run_frame(-1, -1, 1'b0);

    pattern_sel = 1'b1;
    run_frame(-1, -1, 1'b1);
    pattern_sel = 1'b0;
    for (int i = 0; i < NPIX; i++) ram[i] = 8'($urandom);
    run_frame(-1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
